// File: rtl/alu_sequencer.sv
// Multi-cycle control unit for the 32-bit ALU: fetch, decode, execute,
// optional memory wait, and write-back of PC, status flags and register file.
module alu_sequencer #(
  parameter logic [31:0] PC_RESET    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter logic [7:0]  HALT_OPCODE = 8'hFF
) (
  input  logic        Clk,
  input  logic        nRst,
  input  logic        Run,
  output logic        InstrReq,
  output logic [31:0] InstrAddr,
  input  logic [31:0] InstrData,
  input  logic        InstrAck,
  output logic [7:0]  ALU_Sel,
  output logic [23:0] DecoderData,
  output logic        AluEn,
  input  logic [1:0]  MemIO,
  input  logic        ValidMemData,
  input  logic [2:0]  MenagePC,
  input  logic [31:0] PCSet,
  input  logic [7:0]  SetSR,
  output logic [7:0]  StatusReg,
  output logic        RegWrEn,
  output logic [31:0] PC,
  output logic        Busy,
  output logic        Halted,
  output logic        Fault
);

  localparam int unsigned CntW = 8;
  localparam logic [CntW-1:0] TimeoutLast = CntW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXEC    = 3'd3,
    MEMWAIT = 3'd4,
    WB      = 3'd5,
    HALT    = 3'd6,
    FAULT   = 3'd7
  } seqState_t;

  seqState_t       state;
  logic [31:0]     instrReg;
  logic [1:0]      memOp;
  logic [CntW-1:0] timeoutCnt;
  logic            pcCtrlValid;

  // Only keep/advance/jump are legal PC controls; anything else faults in WB.
  assign pcCtrlValid = (MenagePC <= 3'd2);
  assign InstrAddr   = PC;

  always_ff @(posedge Clk) begin
    if (!nRst) begin
      state       <= IDLE;
      PC          <= PC_RESET;
      instrReg    <= '0;
      memOp       <= '0;
      timeoutCnt  <= '0;
      ALU_Sel     <= '0;
      DecoderData <= '0;
      StatusReg   <= '0;
      InstrReq    <= 1'b0;
      AluEn       <= 1'b0;
      RegWrEn     <= 1'b0;
      Busy        <= 1'b0;
      Halted      <= 1'b0;
      Fault       <= 1'b0;
    end else begin
      AluEn   <= 1'b0;
      RegWrEn <= 1'b0;
      case (state)
        IDLE: begin
          if (Run) begin
            state    <= FETCH;
            InstrReq <= 1'b1;
            Busy     <= 1'b1;
          end
        end
        FETCH: begin
          if (InstrAck) begin
            instrReg <= InstrData;
            InstrReq <= 1'b0;
            state    <= DECODE;
          end
        end
        DECODE: begin
          ALU_Sel     <= instrReg[31:24];
          DecoderData <= instrReg[23:0];
          if (instrReg[31:24] == HALT_OPCODE) begin
            state  <= HALT;
            Busy   <= 1'b0;
            Halted <= 1'b1;
          end else begin
            state <= EXEC;
            AluEn <= 1'b1;
          end
        end
        EXEC: begin
          memOp <= MemIO;
          case (MemIO)
            2'b00: begin
              state   <= WB;
              RegWrEn <= pcCtrlValid;
            end
            2'b01, 2'b10: begin
              state      <= MEMWAIT;
              timeoutCnt <= '0;
            end
            default: begin
              state <= FAULT;
              Busy  <= 1'b0;
              Fault <= 1'b1;
            end
          endcase
        end
        MEMWAIT: begin
          timeoutCnt <= timeoutCnt + CntW'(1);
          // Completion takes priority over a simultaneous timeout.
          if (ValidMemData) begin
            state   <= WB;
            RegWrEn <= pcCtrlValid && (memOp != 2'b10);
          end else if (timeoutCnt == TimeoutLast) begin
            state <= FAULT;
            Busy  <= 1'b0;
            Fault <= 1'b1;
          end
        end
        WB: begin
          if (!pcCtrlValid) begin
            state <= FAULT;
            Busy  <= 1'b0;
            Fault <= 1'b1;
          end else begin
            StatusReg <= SetSR;
            case (MenagePC)
              3'b000:  PC <= PC + 32'd4;
              3'b001:  PC <= PCSet;
              default: PC <= PC;
            endcase
            state    <= Run ? FETCH : IDLE;
            InstrReq <= Run;
            Busy     <= Run;
          end
        end
        HALT: begin
          if (!Run) begin
            state  <= IDLE;
            Halted <= 1'b0;
          end
        end
        FAULT: begin
          state <= FAULT;
        end
      endcase
    end
  end

endmodule
